// File: rtl/ide_strobe_sequencer.sv
// ide_strobe_sequencer: filters sampled IDE DIOR-/DIOW- strobes into register read/write requests.
module ide_strobe_sequencer #(
  parameter int FILT_CYCLES = 2,
  parameter int OE_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dior_n_in,
  input  logic       diow_n_in,
  input  logic       cs0_n_in,
  input  logic       cs1_n_in,
  input  logic [2:0] da_in,
  output logic [3:0] reg_addr,
  output logic       reg_rd,
  output logic       reg_wr,
  output logic       data_cap_en,
  output logic       data_oe,
  output logic       busy,
  output logic [7:0] glitch_cnt,
  output logic [7:0] err_cnt
);
  typedef enum logic [2:0] {IDLE, RD_FILT, RD_ACTIVE, WR_FILT, WR_ACTIVE, RECOVER} state_t;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [4:0] ent, cur;
  logic armed, armed_d, rd_xfer, rd_xfer_d, err_prev;
  logic sel_ok, hi, filt, err_cond, start, accept, glitch;
  assign cur = {cs1_n_in, cs0_n_in, da_in};
  assign sel_ok = cs0_n_in ^ cs1_n_in;
  assign hi = dior_n_in & diow_n_in;
  assign filt = state == RD_FILT || state == WR_FILT;
  assign err_cond = en && state == IDLE &&
                    ((!dior_n_in && !diow_n_in) || (!cs0_n_in && !cs1_n_in && !hi));
  assign start = en && armed && sel_ok && (dior_n_in ^ diow_n_in) && state == IDLE;
  assign accept = filt && cnt == FILT_CYCLES[3:0];
  assign glitch = filt && !accept && (cur != ent ||
                  (state == RD_FILT ? dior_n_in : diow_n_in));
  // a strobe left low across RECOVER or reset must be seen high before it can start a transfer
  assign armed_d = state == IDLE ? (armed | hi) : state == RECOVER ? hi : 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rd_xfer <= 1'b0;
      armed <= 1'b0;
      ent <= '0;
      reg_addr <= '0;
      glitch_cnt <= '0;
      err_cnt <= '0;
      err_prev <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      rd_xfer <= rd_xfer_d;
      armed <= armed_d;
      err_prev <= err_cond;
      if (start) ent <= cur;
      if (accept) reg_addr <= {~ent[4], ent[2:0]};
      if (glitch && glitch_cnt != 8'hff) glitch_cnt <= glitch_cnt + 8'd1;
      if (err_cond && !err_prev && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    rd_xfer_d = rd_xfer;
    case (state)
      IDLE: if (start) begin
        state_d = dior_n_in ? WR_FILT : RD_FILT;
        cnt_d = 4'd1;
      end
      RD_FILT, WR_FILT: begin
        state_d = accept ? (state == RD_FILT ? RD_ACTIVE : WR_ACTIVE) : glitch ? IDLE : state;
        cnt_d = accept ? cnt : glitch ? 4'd0 : cnt + 4'd1;
      end
      RD_ACTIVE: if (dior_n_in) begin
        state_d = RECOVER;
        cnt_d = 4'(OE_HOLD);
        rd_xfer_d = 1'b1;
      end
      WR_ACTIVE: if (diow_n_in) begin
        state_d = RECOVER;
        cnt_d = 4'd1;
        rd_xfer_d = 1'b0;
      end
      RECOVER: begin
        state_d = cnt == 4'd0 ? IDLE : RECOVER;
        cnt_d = cnt == 4'd0 ? cnt : cnt - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    reg_rd = state == RD_FILT && accept;
    reg_wr = state == WR_ACTIVE && diow_n_in;
    data_cap_en = state == WR_ACTIVE && !diow_n_in;
    data_oe = state == RD_ACTIVE || (state == RECOVER && rd_xfer && cnt != 4'd0);
    busy = state != IDLE;
  end
endmodule

// File: doc/ide_strobe_sequencer.md
IDE_STROBE_SEQUENCER -- requirements
Module: ide_strobe_sequencer

Interface
REQ-001 Parameter FILT_CYCLES, default 2: consecutive cycles a strobe must be observed asserted before it is accepted; legal range 1..15.
REQ-002 Parameter OE_HOLD, default 1: cycles data_oe stays high after DIOR- deassertion; legal range 1..15.
REQ-003 clk  input  1  system clock; all inputs are already registered on clk by the status-pin input cells.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 en  input  1  sequencer enable; 0 blocks new transfers.
REQ-006 dior_n_in  input  1  sampled DIOR-, active low.
REQ-007 diow_n_in  input  1  sampled DIOW-, active low.
REQ-008 cs0_n_in  input  1  sampled CS0- (command block), active low.
REQ-009 cs1_n_in  input  1  sampled CS1- (control block), active low.
REQ-010 da_in  input  3  sampled DA[2:0].
REQ-011 reg_addr  output  4  latched register address {cs1 selected, da}.
REQ-012 reg_rd  output  1  one-cycle register read request.
REQ-013 reg_wr  output  1  one-cycle register write commit.
REQ-014 data_cap_en  output  1  write-data capture enable.
REQ-015 data_oe  output  1  IDE data bus output enable.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 glitch_cnt  output  8  saturating count of rejected strobes.
REQ-018 err_cnt  output  8  saturating count of protocol errors.

Function
REQ-019 States: IDLE, RD_FILT, RD_ACTIVE, WR_FILT, WR_ACTIVE, RECOVER; a filter counter (4 bits) is shared by the FILT and RECOVER states.
REQ-020 Valid select: exactly one of cs0_n_in/cs1_n_in low; both low or both high = no select.
REQ-021 IDLE: en=1, valid select, dior_n_in=0, diow_n_in=1 -> RD_FILT with count=1; same with diow_n_in=0, dior_n_in=1 -> WR_FILT with count=1.
REQ-022 IDLE: dior_n_in=0 and diow_n_in=0 together, or a strobe low with both CS low -> stay IDLE, err_cnt+1 once per occurrence (edge of the condition).
REQ-023 FILT states: strobe still low, and select/da unchanged from entry -> count+1; strobe high or select/da changed -> IDLE, glitch_cnt+1.
REQ-024 RD_FILT at count==FILT_CYCLES -> reg_addr latched, reg_rd=1 for exactly that cycle, data_oe=1 from the next cycle, -> RD_ACTIVE.
REQ-025 WR_FILT at count==FILT_CYCLES -> reg_addr latched, -> WR_ACTIVE; with FILT_CYCLES=1 acceptance occurs on the cycle after IDLE exit.
REQ-026 RD_ACTIVE: data_oe held high; dior_n_in=1 observed -> RECOVER with count=OE_HOLD.
REQ-027 WR_ACTIVE: data_cap_en=1 every cycle diow_n_in=0; first cycle diow_n_in=1 -> reg_wr=1 for that cycle, data_cap_en=0, -> RECOVER with count=1.
REQ-028 RECOVER: count-1 per cycle; data_oe stays high while count>0 after a read; count==0 -> data_oe=0, -> IDLE; minimum one RECOVER cycle after any transfer.
REQ-029 A strobe still low when entering IDLE from RECOVER is not a new transfer; it must first be observed high.
REQ-030 en falling mid-transfer: the current transfer completes normally; only IDLE entry is blocked.
REQ-031 CS/DA changes during ACTIVE states are ignored; reg_addr holds its latched value until the next acceptance.
REQ-032 Counters saturate at 255; no wrap.
REQ-033 reg_rd and reg_wr are never high in the same cycle; each fires at most once per transfer.

Reset
REQ-034 rst_n low, at any time including mid-transfer: state=IDLE, reg_addr=0, reg_rd=0, reg_wr=0, data_cap_en=0, data_oe=0, busy=0, glitch_cnt=0, err_cnt=0, filter count=0.
REQ-035 After rst_n rises, a strobe already low is ignored until it has been observed high (REQ-029).

Verification
REQ-036 FILT_CYCLES=2, cs0_n=0, da=7, dior_n low 6 cycles -> reg_rd single pulse 2 cycles after IDLE exit, reg_addr=4'h7, data_oe high through OE_HOLD=1 cycle after dior_n rises.
REQ-037 cs1_n=0, da=6, diow_n low 5 cycles -> data_cap_en high on each low cycle after acceptance, reg_wr pulse on first high cycle, reg_addr=4'hE, data_oe never high.
REQ-038 dior_n low 1 cycle, FILT_CYCLES=2 -> no reg_rd, glitch_cnt=1; repeat 300 times -> glitch_cnt=255.
REQ-039 dior_n and diow_n low together with cs0_n=0 -> no pulses, err_cnt=1; cs0_n and cs1_n low with dior_n low -> err_cnt=2.
REQ-040 rst_n asserted during RD_ACTIVE with dior_n held low -> data_oe=0 immediately; no reg_rd after release until dior_n has been high.
REQ-041 en=0 during WR_ACTIVE -> reg_wr still fires; subsequent strobes ignored, busy=0.
